fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/fetch_outreg.sv | 44 ++++
 rtl/fetch_sequencer.sv | 106 ++++++++++
 tb/tb_fetch_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg: shared widths, opcode field values and fetch-state encoding  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package cpu_pkg;

  localparam int INSTR_W = 18;
  localparam int ADDR_W  = 16;

  // Opcode lives in the two leading (MSB-first) instruction bits
  localparam int OPC_W = 2;
  localparam logic [0:OPC_W-1] DT = 2'b00;
  localparam logic [0:OPC_W-1] MV = 2'b01;
  localparam logic [0:OPC_W-1] OP = 2'b11;

  typedef enum logic [0:1] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } fetch_state_t;

  function automatic logic [0:OPC_W-1] opcode_of(input logic [0:INSTR_W-1] instr);
    return instr[0:OPC_W-1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_outreg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_outreg: instruction/PC output register with valid/ready         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module fetch_outreg #(
  parameter int ADDR_W  = cpu_pkg::ADDR_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               load,
  input  logic               ready,
  input  logic [0:INSTR_W-1] load_instr,
  input  logic [0:ADDR_W-1]  load_pc,
  output logic [0:INSTR_W-1] instr,
  output logic [0:ADDR_W-1]  pc,
  output logic               valid,
  output logic               xfer
);
  import cpu_pkg::*;

  // A flush cycle never counts as a transfer, even if decode is ready
  assign xfer = valid & ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= '0;
      pc    <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      instr <= load_instr;
      pc    <= load_pc;
      valid <= 1'b1;
    end else if (xfer) begin
      valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_sequencer: walks an external ROM and hands words to decode      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module fetch_sequencer #(
  parameter int PROG_LEN = 6,
  parameter int ADDR_W   = cpu_pkg::ADDR_W,
  parameter int INSTR_W  = cpu_pkg::INSTR_W
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  output logic [0:ADDR_W-1]  o_rom_addr,
  input  logic [0:INSTR_W-1] i_rom_instr,
  input  logic               i_start,
  output logic [0:INSTR_W-1] o_instr,
  output logic [0:ADDR_W-1]  o_pc,
  output logic               o_valid,
  input  logic               i_ready,
  input  logic               i_redirect,
  input  logic [0:ADDR_W-1]  i_redirect_addr,
  output logic               o_done,
  output logic [0:15]        o_retired
);
  import cpu_pkg::*;

  localparam logic [0:ADDR_W-1] END_ADDR = ADDR_W'(PROG_LEN);

  fetch_state_t      state, state_nx;
  logic [0:ADDR_W-1] pc, pc_nx;
  logic [0:15]       retired;
  logic              pc_in_prog, redirect_now, start_now, flush, load, xfer;

  assign pc_in_prog   = (pc < END_ADDR);
  assign redirect_now = (state == FETCH) && i_redirect;
  assign start_now    = (state != FETCH) && i_start;
  assign flush        = redirect_now | start_now;
  assign load         = (state == FETCH) && !i_redirect && pc_in_prog && (!o_valid || i_ready);
  assign o_rom_addr   = pc;
  assign o_retired    = retired;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      pc    <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    o_done   = 1'b0;
    case (state)
      IDLE, DONE: begin
        o_done = (state == DONE);
        if (i_start) begin
          state_nx = FETCH;
          pc_nx    = '0;
        end
      end
      FETCH: begin
        if (i_redirect) begin
          pc_nx = i_redirect_addr;
          // Out-of-program targets have nothing to fetch, so finish now
          if (i_redirect_addr >= END_ADDR) state_nx = DONE;
        end else begin
          if (load) pc_nx = pc + ADDR_W'(1);
          if (!pc_in_prog && (!o_valid || xfer)) state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      retired <= '0;
    end else if (start_now) begin
      retired <= '0;
    end else if (xfer && (retired != 16'hFFFF)) begin
      retired <= retired + 16'd1;
    end
  end

  fetch_outreg #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_outreg (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .flush      (flush),
    .load       (load),
    .ready      (i_ready),
    .load_instr (i_rom_instr),
    .load_pc    (pc),
    .instr      (o_instr),
    .pc         (o_pc),
    .valid      (o_valid),
    .xfer       (xfer)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_sequencer: directed bench with a transfer-stream model       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_fetch_sequencer;

  localparam int LEN = 6;

  logic        clk = 1'b0;
  logic        rst_n, start, ready, redirect;
  logic [0:15] redirect_addr, rom_addr, pc_o, retired;
  logic [0:17] rom_instr, instr;
  logic        valid, done;

  int errors = 0;
  int checks = 0;

  logic [0:17] rom [LEN];
  initial begin
    rom[0] = 18'h00038; rom[1] = 18'h32800; rom[2] = 18'h31000;
    rom[3] = 18'h00018; rom[4] = 18'h39000; rom[5] = 18'h31000;
  end

  function automatic logic [0:17] rom_word(input logic [0:15] a);
    return (int'(a) < LEN) ? rom[int'(a)] : 18'h0;
  endfunction

  always_comb rom_instr = rom_word(rom_addr);

  always #5 clk = ~clk;

  fetch_sequencer #(.PROG_LEN(LEN), .ADDR_W(16), .INSTR_W(18)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .o_rom_addr      (rom_addr),
    .i_rom_instr     (rom_instr),
    .i_start         (start),
    .o_instr         (instr),
    .o_pc            (pc_o),
    .o_valid         (valid),
    .i_ready         (ready),
    .i_redirect      (redirect),
    .i_redirect_addr (redirect_addr),
    .o_done          (done),
    .o_retired       (retired)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: mode 0=idle 1=running 2=done; exp_pc is the next address decode must receive
  int mode = 0, exp_pc = 0, cnt = 0, pc_bound = LEN;

  always @(negedge clk) begin
    if (!rst_n) begin
      mode = 0; exp_pc = 0; cnt = 0; pc_bound = LEN;
      check("rst_valid", 32'(valid), 0);
      check("rst_done", 32'(done), 0);
      check("rst_retired", 32'(retired), 0);
      check("rst_pc", 32'(pc_o), 0);
    end else begin
      check("model_done", 32'(done), 32'(mode == 2));
      check("model_retired", 32'(retired), 32'(cnt));
      check("pc_bound", 32'(int'(rom_addr) <= pc_bound), 1);
      if (valid) check("instr_matches_rom", 32'(instr), 32'(rom_word(pc_o)));
      if (mode != 1) check("valid_outside_run", 32'(valid), 0);
      if (mode == 1) begin
        if (redirect) begin
          exp_pc = int'(redirect_addr);
          if (exp_pc > pc_bound) pc_bound = exp_pc;
          if (exp_pc >= LEN) mode = 2;
        end else if (valid && ready) begin
          check("stream_pc", 32'(pc_o), 32'(exp_pc));
          if (cnt < 65535) cnt++;
          exp_pc++;
          if (exp_pc >= LEN) mode = 2;
        end
      end else if (start) begin
        mode = 1; exp_pc = 0; cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_out(input int from);
    for (int k = from; k < LEN; k++) begin
      tick();
      check("runout_pc", 32'(pc_o), 32'(k));
    end
    tick();
    check("runout_done", 32'(done), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [0:17] golden [LEN];
    golden = '{18'h00038, 18'h32800, 18'h31000, 18'h00018, 18'h39000, 18'h31000};
    rst_n = 1'b0; start = 1'b0; ready = 1'b1; redirect = 1'b0; redirect_addr = '0;
    tick(); tick();
    check("reset_instr", 32'(instr), 0);
    check("reset_rom_addr", 32'(rom_addr), 0);
    rst_n = 1'b1;
    tick(); tick();
    check("idle_valid", 32'(valid), 0);
    check("idle_done", 32'(done), 0);

    // Straight run with decode always ready
    start_run();
    check("start_latency_valid", 32'(valid), 0);
    for (int k = 0; k < LEN; k++) begin
      tick();
      check("t1_valid", 32'(valid), 1);
      check("t1_pc", 32'(pc_o), 32'(k));
      check("t1_instr", 32'(instr), 32'(golden[k]));
    end
    tick();
    check("t1_done", 32'(done), 1);
    check("t1_retired", 32'(retired), 6);
    check("t1_valid_off", 32'(valid), 0);

    // Backpressure on pc 2
    start_run();
    tick(); tick(); tick();
    check("t2_pc2", 32'(pc_o), 2);
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t2_hold_pc", 32'(pc_o), 2);
      check("t2_hold_instr", 32'(instr), 32'h31000);
      check("t2_hold_valid", 32'(valid), 1);
      check("t2_hold_fetch_pc", 32'(rom_addr), 3);
    end
    ready = 1'b1;
    run_out(3);
    check("t2_retired", 32'(retired), 6);

    // Redirect back to 1 while pc 4 is pending
    start_run();
    for (int k = 0; k < 5; k++) tick();
    check("t3_pc4", 32'(pc_o), 4);
    redirect = 1'b1; redirect_addr = 16'd1;
    tick();
    redirect = 1'b0;
    check("t3_flush_valid", 32'(valid), 0);
    check("t3_fetch_pc", 32'(rom_addr), 1);
    check("t3_retired", 32'(retired), 4);
    tick();
    check("t3_valid", 32'(valid), 1);
    check("t3_pc", 32'(pc_o), 1);
    check("t3_instr", 32'(instr), 32'h32800);
    run_out(2);
    check("t3_retired_end", 32'(retired), 9);

    // Redirect beyond the program finishes immediately
    start_run();
    check("t4_cleared", 32'(retired), 0);
    tick(); tick();
    redirect = 1'b1; redirect_addr = 16'd9;
    tick();
    redirect = 1'b0;
    check("t4_done", 32'(done), 1);
    check("t4_valid", 32'(valid), 0);
    check("t4_retired", 32'(retired), 1);
    check("t4_fetch_pc", 32'(rom_addr), 9);
    redirect = 1'b1; redirect_addr = 16'd2;
    tick();
    redirect = 1'b0;
    check("t4_redirect_ignored_done", 32'(done), 1);
    check("t4_redirect_ignored_pc", 32'(rom_addr), 9);

    // Asynchronous reset mid-run at pc 3
    start_run();
    for (int k = 0; k < 4; k++) tick();
    check("t5_pc3", 32'(pc_o), 3);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_valid", 32'(valid), 0);
    check("t5_async_pc", 32'(pc_o), 0);
    check("t5_async_instr", 32'(instr), 0);
    check("t5_async_retired", 32'(retired), 0);
    check("t5_async_done", 32'(done), 0);
    check("t5_async_rom_addr", 32'(rom_addr), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    check("t5_idle_valid", 32'(valid), 0);
    check("t5_idle_done", 32'(done), 0);
    start_run();
    tick();
    check("t5_restart_valid", 32'(valid), 1);
    check("t5_restart_pc", 32'(pc_o), 0);
    run_out(1);

    // Start and redirect together in DONE: start wins
    start = 1'b1; redirect = 1'b1; redirect_addr = 16'd3;
    tick();
    start = 1'b0; redirect = 1'b0;
    check("t6_retired", 32'(retired), 0);
    check("t6_done", 32'(done), 0);
    check("t6_fetch_pc", 32'(rom_addr), 0);
    tick();
    check("t6_pc", 32'(pc_o), 0);
    check("t6_valid", 32'(valid), 1);
    run_out(1);
    check("t6_retired_end", 32'(retired), 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
